// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch stage with IF/ID register, one-entry hold buffer
//            and redirect/flush handling over a req/ack instruction memory port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  input  logic                  flush,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_valid
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_disc_addr;
  logic [DATA_WIDTH-1:0] r_hold_instr;
  logic [ADDR_WIDTH-1:0] r_if_pc;
  logic [DATA_WIDTH-1:0] r_if_instr;
  logic                  r_if_valid;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_load_fetch;
  logic                  w_load_hold;
  logic                  w_capture;
  logic                  w_bubble;
  logic                  w_enter_discard;

  // A flush without a branch redirects to the current pc so the dropped word is refetched.
  assign w_redirect = use_branch | flush;
  assign w_target   = use_branch ? {branch_out[ADDR_WIDTH-1:2], 2'b00} : r_pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_redirect) begin
          w_state_next = imem_ack ? S_FETCH : S_DISCARD;
        end else if (imem_ack && stall) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_redirect || !stall) begin
          w_state_next = S_FETCH;
        end
      end
      S_DISCARD: begin
        // Once the stale word lands, fetch resumes at the (possibly re-targeted) pc.
        if (imem_ack) begin
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Output / action decode
  always_comb begin
    imem_req        = reset && (r_state != S_HOLD);
    imem_addr       = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
    w_load_fetch    = 1'b0;
    w_load_hold     = 1'b0;
    w_capture       = 1'b0;
    w_bubble        = 1'b0;
    w_enter_discard = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_load_fetch    = !w_redirect && imem_ack && !stall;
        w_capture       = !w_redirect && imem_ack && stall;
        w_bubble        = !w_redirect && !imem_ack && !stall;
        w_enter_discard = w_redirect && !imem_ack;
      end
      S_HOLD: begin
        w_load_hold = !w_redirect && !stall;
      end
      default: ;
    endcase
  end

  // Datapath: pc, discard address, hold buffer and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= PC_ADDR;
      r_disc_addr  <= PC_ADDR;
      r_hold_instr <= '0;
      r_if_pc      <= PC_ADDR;
      r_if_instr   <= '0;
      r_if_valid   <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc       <= w_target;
        r_if_valid <= 1'b0;
      end else if (w_load_fetch || w_load_hold) begin
        r_pc       <= r_pc + c_pc_step;
        r_if_pc    <= r_pc;
        r_if_instr <= w_load_fetch ? imem_rdata : r_hold_instr;
        r_if_valid <= 1'b1;
      end else if (w_bubble) begin
        r_if_valid <= 1'b0;
      end
      if (w_capture) begin
        r_hold_instr <= imem_rdata;
      end
      // The in-flight address must stay on the bus while pc already holds the new target.
      if (w_enter_discard) begin
        r_disc_addr <= r_pc;
      end
    end
  end

  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch: directed scenarios with literal
//            expectations, then randomized traffic against a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] c_rst_pc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        use_branch = 1'b0;
  logic [31:0] branch_out = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory returns a word that is a pure function of the address it was asked for.
  assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'h0;

  instr_fetch #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PC_ADDR   (c_rst_pc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .use_branch(use_branch),
    .branch_out(branch_out),
    .flush     (flush),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_valid  (if_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model in transaction terms: the address being fetched, whether its
  // word is still wanted, a held word waiting for decode, and the IF/ID contents.
  logic [31:0] m_pc, m_addr, m_held_word, m_if_pc, m_if_instr;
  logic        m_want, m_held, m_if_valid;
  logic        m_redir;
  logic [31:0] m_tgt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= c_rst_pc; m_addr <= c_rst_pc; m_want <= 1'b1; m_held <= 1'b0;
      m_held_word <= '0; m_if_pc <= c_rst_pc; m_if_instr <= '0; m_if_valid <= 1'b0;
    end else begin
      m_redir = use_branch | flush;
      m_tgt   = use_branch ? (branch_out & ~32'h3) : m_pc;
      if (m_held) begin
        if (m_redir) begin
          m_held <= 1'b0; m_if_valid <= 1'b0;
          m_pc <= m_tgt; m_addr <= m_tgt; m_want <= 1'b1;
        end else if (!stall) begin
          m_if_pc <= m_pc; m_if_instr <= m_held_word; m_if_valid <= 1'b1;
          m_pc <= m_pc + 32'd4; m_addr <= m_pc + 32'd4; m_want <= 1'b1; m_held <= 1'b0;
        end
      end else if (m_redir) begin
        m_if_valid <= 1'b0; m_pc <= m_tgt;
        if (imem_ack) begin m_addr <= m_tgt; m_want <= 1'b1; end
        else m_want <= 1'b0;
      end else if (!m_want) begin
        if (imem_ack) begin m_addr <= m_pc; m_want <= 1'b1; end
      end else if (imem_ack) begin
        if (stall) begin
          m_held <= 1'b1; m_held_word <= word_at(m_addr);
        end else begin
          m_if_pc <= m_addr; m_if_instr <= word_at(m_addr); m_if_valid <= 1'b1;
          m_pc <= m_addr + 32'd4; m_addr <= m_addr + 32'd4;
        end
      end else if (!stall) begin
        m_if_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("imem_req", {31'b0, imem_req}, {31'b0, reset && !m_held});
    if (reset && !m_held) chk("imem_addr", imem_addr, m_addr);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
    chk("if_pc", if_pc, m_if_pc);
    chk("if_instr", if_instr, m_if_instr);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_idle();
    use_branch = 1'b0; flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    // Reset state
    cyc(); cyc(); cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h8000_0000);
    chk("rst_if_instr", if_instr, 32'h0);
    reset = 1'b1; #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h8000_0000);
    imem_ack = 1'b1;
    cyc();
    chk("seq_if_pc0", if_pc, 32'h8000_0000);
    chk("seq_valid0", {31'b0, if_valid}, 32'd1);
    chk("seq_instr0", if_instr, word_at(32'h8000_0000));
    chk("seq_addr1", imem_addr, 32'h8000_0004);
    // Ack for 0x80000004 arrives under stall held for three cycles
    stall = 1'b1;
    cyc();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_if_pc", if_pc, 32'h8000_0000);
    imem_ack = 1'b0;
    cyc(); cyc();
    chk("hold_if_pc2", if_pc, 32'h8000_0000);
    stall = 1'b0;
    cyc();
    chk("release_if_pc", if_pc, 32'h8000_0004);
    chk("release_addr", imem_addr, 32'h8000_0008);
    // Branch while 0x80000008 is outstanding, ack three cycles late
    use_branch = 1'b1; branch_out = 32'h8000_0100;
    cyc();
    chk("disc_addr", imem_addr, 32'h8000_0008);
    chk("disc_valid", {31'b0, if_valid}, 32'd0);
    use_branch = 1'b0;
    cyc(); cyc();
    chk("disc_addr_late", imem_addr, 32'h8000_0008);
    imem_ack = 1'b1;
    cyc();
    chk("after_disc_addr", imem_addr, 32'h8000_0100);
    chk("after_disc_valid", {31'b0, if_valid}, 32'd0);
    // Misaligned target is word-aligned
    use_branch = 1'b1; branch_out = 32'h8000_0102;
    cyc();
    chk("align_addr", imem_addr, 32'h8000_0100);
    use_branch = 1'b0;
    cyc();
    chk("align_if_pc", if_pc, 32'h8000_0100);
    // Branch beats stall
    use_branch = 1'b1; stall = 1'b1; branch_out = 32'h8000_0200; imem_ack = 1'b0;
    cyc();
    chk("br_stall_valid", {31'b0, if_valid}, 32'd0);
    use_branch = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    cyc();
    chk("br_stall_addr", imem_addr, 32'h8000_0200);
    // Reset pulled low mid-request at 0x8000000C
    imem_ack = 1'b0; reset = 1'b0;
    cyc();
    reset = 1'b1; imem_ack = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_rst_addr", imem_addr, 32'h8000_000C);
    imem_ack = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'b0, if_valid}, 32'd0);
    cyc();
    reset = 1'b1; #1;
    chk("post_rst_addr", imem_addr, 32'h8000_0000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      drive_idle();
      if (!reset) reset = 1'b1;
      stall = ($urandom_range(0, 99) < 30);
      imem_ack = imem_req && ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 8) begin
        use_branch = 1'b1;
        case ($urandom_range(0, 3))
          0, 3: begin
            t = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            branch_out = t | 32'($urandom_range(0, 3));
          end
          1: branch_out = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          default: branch_out = $urandom;
        endcase
      end
      if ($urandom_range(0, 99) < 5) flush = 1'b1;
      if ($urandom_range(0, 999) < 3) begin
        #3 reset = 1'b0;
      end
    end
    cyc();
    drive_idle();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
